// File: rtl/fetch_stage_if.sv
// fetch_stage_if: bundles the fetch stage's handshake and bus signals.
//   Decode side : stall (in), if_pc / if_instr / if_valid (out)
//   Execute side: redirect, redirect_pc (in)
//   IMEM side   : imem_en, imem_addr (out), imem_dout (in, one cycle late)
// The master modport is the fetch stage itself; slave is its environment.
interface fetch_stage_if #(
  parameter int IMEM_AW = 14
);
  logic               stall;
  logic               redirect;
  logic [31:0]        redirect_pc;
  logic               imem_en;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_dout;
  logic [31:0]        if_pc;
  logic [31:0]        if_instr;
  logic               if_valid;

  modport master (
    input  stall, redirect, redirect_pc, imem_dout,
    output imem_en, imem_addr, if_pc, if_instr, if_valid
  );

  modport slave (
    output stall, redirect, redirect_pc, imem_dout,
    input  imem_en, imem_addr, if_pc, if_instr, if_valid
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction fetch. Owns the PC, issues word addresses to
// a synchronous-read instruction memory and presents pc/instr/valid to decode.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   bus      : fetch_stage_if master (stall/redirect in, imem bus, decode outputs)
// A skid register catches the memory's late read data when decode stalls, so
// release resumes with no bubble and no duplicate.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000,
  parameter int          IMEM_AW  = 14
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);

  logic [31:0] npc;
  logic        req_valid;
  logic [31:0] req_pc;
  logic        hold_valid;
  logic [31:0] hold_pc;
  logic [31:0] hold_instr;

  logic        issue;
  logic [31:0] issue_pc;

  // Redirect overrides stall; the target's low two bits are forced to zero.
  assign issue    = bus.redirect | ~bus.stall;
  assign issue_pc = bus.redirect ? (bus.redirect_pc & 32'hFFFF_FFFC) : npc;

  assign bus.imem_en   = issue & ~rst;
  assign bus.imem_addr = issue_pc[IMEM_AW+1:2];

  // Held instruction takes precedence over the in-flight read's data.
  always_comb begin
    bus.if_valid = 1'b0;
    bus.if_pc    = 32'h0;
    bus.if_instr = 32'h0;
    if (hold_valid) begin
      bus.if_valid = 1'b1;
      bus.if_pc    = hold_pc;
      bus.if_instr = hold_instr;
    end else if (req_valid) begin
      bus.if_valid = 1'b1;
      bus.if_pc    = req_pc;
      bus.if_instr = bus.imem_dout;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      npc        <= RESET_PC;
      req_valid  <= 1'b0;
      req_pc     <= 32'h0;
      hold_valid <= 1'b0;
      hold_pc    <= 32'h0;
      hold_instr <= 32'h0;
    end else begin
      // Skid register: capture the late memory data only on the first stalled
      // cycle; later stalled cycles leave it untouched.
      if (bus.redirect) begin
        hold_valid <= 1'b0;
      end else if (bus.stall) begin
        if (req_valid && !hold_valid) begin
          hold_valid <= 1'b1;
          hold_pc    <= req_pc;
          hold_instr <= bus.imem_dout;
        end
      end else begin
        hold_valid <= 1'b0;
      end

      if (issue) begin
        req_valid <= 1'b1;
        req_pc    <= issue_pc;
        npc       <= issue_pc + 32'd4;
      end else begin
        req_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: self-checking bench for fetch_stage. A program-order model
// tracks what decode should see: the presented pc and the next address in
// program order, updated per clock from stall/redirect.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h4000_0000;
  localparam int          IMEM_AW  = 14;

  logic clk;
  logic rst;

  fetch_stage_if #(.IMEM_AW(IMEM_AW)) bus ();

  fetch_stage #(.RESET_PC(RESET_PC), .IMEM_AW(IMEM_AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] mem [0:(1<<IMEM_AW)-1];

  // Model state: what decode should see and the next program-order address.
  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_next;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous-read instruction memory.
  always @(posedge clk) begin
    if (bus.imem_en) bus.imem_dout <= mem[bus.imem_addr];
  end

  function automatic logic [31:0] exp_instr(input logic [31:0] pc);
    return mem[pc[IMEM_AW+1:2]];
  endfunction

  function automatic logic [IMEM_AW-1:0] word_of(input logic [31:0] pc);
    return pc[IMEM_AW+1:2];
  endfunction

  task automatic set_in(input logic s, input logic r, input logic [31:0] rp);
    bus.stall       = s;
    bus.redirect    = r;
    bus.redirect_pc = rp;
    #1;
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_pc    = 32'h0;
    m_next  = RESET_PC;
  endtask

  // One clock: model follows program order, then sample 1 time unit later.
  task automatic advance();
    logic s, r;
    logic [31:0] rp;
    s  = bus.stall;
    r  = bus.redirect;
    rp = bus.redirect_pc;
    @(posedge clk);
    if (r) begin
      m_valid = 1'b1;
      m_pc    = {rp[31:2], 2'b00};
      m_next  = {rp[31:2], 2'b00} + 32'd4;
    end else if (!s) begin
      m_valid = 1'b1;
      m_pc    = m_next;
      m_next  = m_next + 32'd4;
    end
    #1;
  endtask

  task automatic test_reset();
    tests_run++;
    if (bus.if_valid !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL reset_valid got %0b want 0", bus.if_valid);
    end
    tests_run++;
    if (bus.imem_en !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL reset_en got %0b want 0", bus.imem_en);
    end
    tests_run++;
    if (bus.if_pc !== 32'h0) begin
      tests_failed++; $display("[TB] FAIL reset_pc got %h want 0", bus.if_pc);
    end
    tests_run++;
    if (bus.if_instr !== 32'h0) begin
      tests_failed++; $display("[TB] FAIL reset_instr got %h want 0", bus.if_instr);
    end
  endtask

  task automatic test_startup();
    rst = 1'b0;
    model_reset();
    set_in(1'b0, 1'b0, 32'h0);
    tests_run++;
    if (bus.imem_en !== 1'b1 || bus.imem_addr !== word_of(RESET_PC)) begin
      tests_failed++;
      $display("[TB] FAIL start_issue got en=%0b addr=%h want en=1 addr=%h",
               bus.imem_en, bus.imem_addr, word_of(RESET_PC));
    end
    advance();
    tests_run++;
    if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h4000_0000 || bus.if_instr !== 32'h0050_0093) begin
      tests_failed++;
      $display("[TB] FAIL start_first got v=%0b pc=%h instr=%h want v=1 pc=40000000 instr=00500093",
               bus.if_valid, bus.if_pc, bus.if_instr);
    end
    advance();
    tests_run++;
    if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h4000_0004 || bus.if_instr !== 32'h0010_0113) begin
      tests_failed++;
      $display("[TB] FAIL start_second got v=%0b pc=%h instr=%h want v=1 pc=40000004 instr=00100113",
               bus.if_valid, bus.if_pc, bus.if_instr);
    end
  endtask

  task automatic test_stall();
    advance();
    tests_run++;
    if (bus.if_pc !== 32'h4000_0008) begin
      tests_failed++; $display("[TB] FAIL stall_pre_pc got %h want 40000008", bus.if_pc);
    end
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 1'b0, 32'h0);
      tests_run++;
      if (bus.imem_en !== 1'b0) begin
        tests_failed++; $display("[TB] FAIL stall_en cycle %0d got %0b want 0", i, bus.imem_en);
      end
      advance();
      tests_run++;
      if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h4000_0008 ||
          bus.if_instr !== exp_instr(32'h4000_0008)) begin
        tests_failed++;
        $display("[TB] FAIL stall_hold cycle %0d got v=%0b pc=%h instr=%h want v=1 pc=40000008 instr=%h",
                 i, bus.if_valid, bus.if_pc, bus.if_instr, exp_instr(32'h4000_0008));
      end
    end
    set_in(1'b0, 1'b0, 32'h0);
    tests_run++;
    if (bus.imem_en !== 1'b1 || bus.imem_addr !== word_of(32'h4000_000C)) begin
      tests_failed++;
      $display("[TB] FAIL release_issue got en=%0b addr=%h want en=1 addr=%h",
               bus.imem_en, bus.imem_addr, word_of(32'h4000_000C));
    end
    advance();
    tests_run++;
    if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h4000_000C ||
        bus.if_instr !== exp_instr(32'h4000_000C)) begin
      tests_failed++;
      $display("[TB] FAIL release_next got v=%0b pc=%h instr=%h want v=1 pc=4000000c instr=%h",
               bus.if_valid, bus.if_pc, bus.if_instr, exp_instr(32'h4000_000C));
    end
  endtask

  task automatic test_redirect();
    set_in(1'b0, 1'b1, 32'h4000_0103);
    tests_run++;
    if (bus.imem_en !== 1'b1 || bus.imem_addr !== word_of(32'h4000_0100)) begin
      tests_failed++;
      $display("[TB] FAIL redir_issue got en=%0b addr=%h want en=1 addr=%h",
               bus.imem_en, bus.imem_addr, word_of(32'h4000_0100));
    end
    advance();
    tests_run++;
    if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h4000_0100 ||
        bus.if_instr !== exp_instr(32'h4000_0100)) begin
      tests_failed++;
      $display("[TB] FAIL redir_target got v=%0b pc=%h instr=%h want v=1 pc=40000100",
               bus.if_valid, bus.if_pc, bus.if_instr);
    end
    set_in(1'b0, 1'b0, 32'h0);
    advance();
    tests_run++;
    if (bus.if_pc !== 32'h4000_0104 || bus.if_instr !== exp_instr(32'h4000_0104)) begin
      tests_failed++;
      $display("[TB] FAIL redir_next got pc=%h instr=%h want pc=40000104", bus.if_pc, bus.if_instr);
    end
  endtask

  task automatic test_redirect_while_held();
    set_in(1'b1, 1'b0, 32'h0);
    advance();
    advance();
    set_in(1'b1, 1'b1, 32'h4000_0200);
    tests_run++;
    if (bus.imem_en !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL held_redir_en got %0b want 1", bus.imem_en);
    end
    advance();
    tests_run++;
    if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h4000_0200 ||
        bus.if_instr !== exp_instr(32'h4000_0200)) begin
      tests_failed++;
      $display("[TB] FAIL held_redir got v=%0b pc=%h instr=%h want v=1 pc=40000200",
               bus.if_valid, bus.if_pc, bus.if_instr);
    end
    set_in(1'b0, 1'b0, 32'h0);
    advance();
    tests_run++;
    if (bus.if_pc !== 32'h4000_0204) begin
      tests_failed++; $display("[TB] FAIL held_redir_next got %h want 40000204", bus.if_pc);
    end
  endtask

  task automatic test_async_reset();
    advance();
    rst = 1'b1;
    #1;
    tests_run++;
    if (bus.if_valid !== 1'b0 || bus.imem_en !== 1'b0 || bus.if_pc !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL async_rst got v=%0b en=%0b pc=%h want v=0 en=0 pc=0",
               bus.if_valid, bus.imem_en, bus.if_pc);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    set_in(1'b0, 1'b0, 32'h0);
    tests_run++;
    if (bus.if_valid !== 1'b0 || bus.imem_addr !== word_of(RESET_PC)) begin
      tests_failed++;
      $display("[TB] FAIL async_rst_restart got v=%0b addr=%h want v=0 addr=%h",
               bus.if_valid, bus.imem_addr, word_of(RESET_PC));
    end
    advance();
    tests_run++;
    if (bus.if_valid !== 1'b1 || bus.if_pc !== RESET_PC) begin
      tests_failed++;
      $display("[TB] FAIL async_rst_first got v=%0b pc=%h want v=1 pc=%h",
               bus.if_valid, bus.if_pc, RESET_PC);
    end
  endtask

  task automatic test_wrap();
    set_in(1'b0, 1'b1, 32'hFFFF_FFFC);
    advance();
    tests_run++;
    if (bus.if_pc !== 32'hFFFF_FFFC) begin
      tests_failed++; $display("[TB] FAIL wrap_target got %h want fffffffc", bus.if_pc);
    end
    set_in(1'b0, 1'b0, 32'h0);
    advance();
    tests_run++;
    if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0 || bus.if_instr !== 32'h0050_0093) begin
      tests_failed++;
      $display("[TB] FAIL wrap_next got v=%0b pc=%h instr=%h want v=1 pc=0 instr=00500093",
               bus.if_valid, bus.if_pc, bus.if_instr);
    end
  endtask

  task automatic test_random();
    logic s, r;
    logic [31:0] rp, want_addr;
    for (int i = 0; i < 400; i++) begin
      s  = ($urandom_range(0, 99) < 35);
      r  = ($urandom_range(0, 99) < 10);
      rp = $urandom;
      set_in(s, r, rp);
      want_addr = r ? {rp[31:2], 2'b00} : m_next;
      tests_run++;
      if (bus.imem_en !== (r | ~s) ||
          ((r | ~s) && bus.imem_addr !== word_of(want_addr))) begin
        tests_failed++;
        $display("[TB] FAIL rand_issue cycle %0d got en=%0b addr=%h want en=%0b addr=%h",
                 i, bus.imem_en, bus.imem_addr, r | ~s, word_of(want_addr));
      end
      advance();
      tests_run++;
      if (bus.if_valid !== m_valid ||
          bus.if_pc !== (m_valid ? m_pc : 32'h0) ||
          bus.if_instr !== (m_valid ? exp_instr(m_pc) : 32'h0)) begin
        tests_failed++;
        $display("[TB] FAIL rand_present cycle %0d got v=%0b pc=%h instr=%h want v=%0b pc=%h instr=%h",
                 i, bus.if_valid, bus.if_pc, bus.if_instr, m_valid,
                 m_valid ? m_pc : 32'h0, m_valid ? exp_instr(m_pc) : 32'h0);
      end
    end
    set_in(1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < (1 << IMEM_AW); i++) begin
      mem[i] = (i * 32'h9E37_79B9) ^ 32'h1234_5678;
    end
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h0010_0113;

    rst             = 1'b1;
    bus.stall       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.imem_dout   = 32'h0;
    model_reset();

    @(posedge clk);
    @(posedge clk);
    #1;
    test_reset();
    test_startup();
    test_stall();
    test_redirect();
    test_redirect_while_held();
    test_async_reset();
    test_wrap();
    test_random();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the RV32I pipeline. It owns the program counter, issues word addresses to the synchronous-read instruction memory, and presents `if_pc`/`if_instr`/`if_valid` to the decode stage, where the instruction is split into opcode/funct fields and the immediate generator consumes `if_instr`. It handles decode back-pressure without losing the memory's one-cycle-late read data, and handles redirects from the execute stage for taken branches, JAL and JALR.

## Interface
- `RESET_PC`, default 32'h4000_0000: first instruction address fetched after reset.
- `IMEM_AW`, default 14: instruction memory word-address width.
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `stall`  in  1  decode cannot accept the presented instruction this cycle.
- `redirect`  in  1  execute stage demands a fetch from `redirect_pc`.
- `redirect_pc`  in  32  redirect target byte address; bits [1:0] are ignored and treated as 0.
- `imem_en`  out  1  read enable to the instruction memory.
- `imem_addr`  out  IMEM_AW  word address, equal to `issue_pc[IMEM_AW+1:2]`.
- `imem_dout`  in  32  read data, valid on the cycle after `imem_en` was asserted.
- `if_pc`  out  32  byte PC of the presented instruction.
- `if_instr`  out  32  presented instruction.
- `if_valid`  out  1  `if_pc`/`if_instr` are meaningful.

## Operation
- State:
  - `npc` (32): next sequential address to issue; resets to RESET_PC.
  - `req_valid`/`req_pc`: a read was issued last cycle; `imem_dout` belongs to `req_pc`.
  - `hold_valid`/`hold_pc`/`hold_instr`: skid register.
  - While `rst` is high, `req_valid=0`, `hold_valid=0`, `imem_en=0`.
- Output mux (combinational):
  - If `hold_valid`, present `hold_pc`/`hold_instr` with `if_valid=1`.
  - Else if `req_valid`, present `req_pc`/`imem_dout` with `if_valid=1`.
  - Else `if_valid=0`, with `if_pc`/`if_instr` don't-care; drive them 0.
- Issue rule:
  - `issue = redirect | ~stall`.
  - `issue_pc = redirect ? {redirect_pc[31:2],2'b00} : npc`.
  - `imem_en = issue & ~rst`.
  - On issue: `req_valid<=1`, `req_pc<=issue_pc`, `npc<=issue_pc+4` (mod 2^32).
- Redirect, highest priority:
  - Clears `hold_valid`.
  - Overrides `stall`.
  - Replaces any in-flight read. The wrong-path instruction presented in the redirect cycle is left as is; downstream squashes it.
- Stall without redirect:
  - No issue; `req_valid<=0`.
  - If `req_valid & ~hold_valid`: capture `hold_pc<=req_pc`, `hold_instr<=imem_dout`, `hold_valid<=1`.
  - If `hold_valid`: hold unchanged.
  - Stall while `if_valid=0` only suppresses issue.
- No stall, no redirect: the presented instruction is consumed, `hold_valid<=0`, and `npc` is issued.
- No internal FSM beyond these flags. Effective states:
  - EMPTY (`req_valid=0`, `hold_valid=0`)
  - STREAM (`req_valid=1`)
  - HELD (`hold_valid=1`)
  - EMPTY→STREAM on issue. STREAM→HELD on stall. HELD→STREAM on release. Any state→STREAM on redirect.

## Timing
- Reset values: `if_valid=0`, `imem_en=0`, `if_pc=0`, `if_instr=0`, `npc=RESET_PC`.
- First cycle after `rst` falls: `imem_en=1`, `imem_addr=RESET_PC>>2`. Next cycle: `if_valid=1`, `if_pc=RESET_PC`.
- Fetch latency is 1 cycle from issue to presentation. Steady-state throughput is 1 instruction/cycle.
- Stall release: the held instruction is consumed in the release cycle and `npc` is issued in the same cycle. The following instruction is presented next cycle, with no bubble and no duplicate.
- Redirect in cycle t: target presented in t+1 with `if_valid=1`, whatever `stall` was in t.
- `rst` asserted mid-stream: outputs return to reset values immediately (asynchronous). Any in-flight or held instruction is discarded.
- `npc` wraps 32'hFFFF_FFFC → 32'h0000_0000.

## Test plan
- Reset release, no stall, memory preloaded at 0x4000_0000 with 0x00500093, 0x00100113: `if_pc`=0x4000_0000 then 0x4000_0004, `if_instr` matches, `if_valid` continuously 1 from the second cycle.
- Stall held 3 cycles while presenting 0x4000_0008: `if_pc`/`if_instr` stay constant, `imem_en=0` during the stall. After release, 0x4000_000C follows with no gap and no repeat.
- Redirect to 0x4000_0100 with `redirect_pc[1:0]=2'b11`: next cycle `if_pc`=0x4000_0100, then 0x4000_0104.
- Redirect and stall in the same cycle while HELD: hold dropped; next cycle shows the redirect target with `if_valid=1`.
- `rst` pulsed asynchronously mid-stream: `if_valid` drops without waiting for a clock edge; after release fetch restarts at RESET_PC.
- Redirect to 0xFFFF_FFFC: the next sequential `if_pc` is 0x0000_0000.
